// File: rtl/replica_pkg.sv
// replica_pkg: shared sizing and packed word type for one replica node
package replica_pkg;
    localparam int city_num_log = 5;
    localparam int city_div     = 4;
    localparam int city_div_log = 2;
    localparam int base_log     = 2;
    typedef logic [7:0][city_num_log-1:0] replica_data_t;
endpackage

// File: rtl/route_pack.sv
// route_pack: packs a route, one city per handshake, into 8-lane words for the exchange write port
module route_pack
    import replica_pkg::*;
#(
    parameter int lead_cycles = 3,
    parameter int lanes       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [base_log-1:0]     base_id,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [city_num_log-1:0] in_city,
    output logic [base_log-1:0]     out_base_id,
    output logic                    out_valid,
    output replica_data_t           out_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LEAD = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam int lead_w = lead_cycles > 1 ? $clog2(lead_cycles) : 1;
    localparam logic [lead_w-1:0] lead_last = lead_w'(lead_cycles - 1);
    localparam logic [city_div_log-1:0] word_last = city_div_log'(city_div - 1);
    localparam logic [2:0] lane_last = 3'(lanes - 1);

    logic [1:0]                         state;
    logic [lead_w-1:0]                  lead_cnt;
    logic [2:0]                         lane_cnt;
    logic [city_div_log-1:0]            word_cnt;
    logic [6:0][city_num_log-1:0]       asm_q;

    // handshake and status follow the state directly
    always_comb begin
        busy     = state != IDLE;
        in_ready = state == FILL;
    end

    // sequencing: latch base on start, wait out the receiver's base delay, then gather cities
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lead_cnt    <= '0;
            lane_cnt    <= '0;
            word_cnt    <= '0;
            asm_q       <= '0;
            out_base_id <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            done        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    out_base_id <= base_id;
                    lead_cnt    <= '0;
                    lane_cnt    <= '0;
                    word_cnt    <= '0;
                    state       <= lead_cycles == 0 ? FILL : LEAD;
                end
                LEAD: begin
                    lead_cnt <= lead_cnt + 1'b1;
                    state    <= lead_cnt == lead_last ? FILL : LEAD;
                end
                FILL: if (in_valid) begin
                    lane_cnt <= lane_cnt + 1'b1;
                    if (lane_cnt == lane_last) begin
                        out_data  <= {in_city, asm_q};
                        out_valid <= 1'b1;
                        word_cnt  <= word_cnt + 1'b1;
                        done      <= word_cnt == word_last;
                        state     <= word_cnt == word_last ? IDLE : FILL;
                    end else begin
                        asm_q[lane_cnt] <= in_city;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
